// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipe.
// Drives fetch/decode stalls and decode/execute flushes. Produces registered forwarding
// selects that line up with the decode-execute register outputs.
// Optional feature: define STALL_CNT_EN to get saturating stall/flush event counters.
// With STALL_CNT_EN undefined, the counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int unsigned M     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     regAD,
    input  logic [M-1:0]     regBD,
    input  logic [M-1:0]     regScr_E,
    input  logic             regw_E,
    input  logic             regmem_E,
    input  logic [M-1:0]     regScr_M,
    input  logic             regw_M,
    input  logic             branch_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StLuStall,
        StBrFlush
    } state_e;

    state_e     state_q, state_d;
    logic       lu;
    logic [1:0] fwd_a_d, fwd_a_q;
    logic [1:0] fwd_b_d, fwd_b_q;

    // Forward select for one decode source; the E-stage producer is younger, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [M-1:0] src,
                                           input logic [M-1:0] dst_e, input logic w_e,
                                           input logic [M-1:0] dst_m, input logic w_m);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (w_e && (src == dst_e)) begin
                sel = 2'b10;
            end else if (w_m && (src == dst_m)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Load in E whose destination feeds a decode source; register 0 never counts.
    assign lu = regmem_E & regw_E & (regScr_E != '0) &
                ((regScr_E == regAD) | (regScr_E == regBD));

    // Next-state and stall/flush outputs; a taken branch always beats a load-use.
    always_comb begin
        state_d = state_q;
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        if (!rst) begin
            // Keep E empty while reset is held.
            flush_E = 1'b1;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (branch_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                        state_d = StBrFlush;
                    end else if (lu) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                        state_d = StLuStall;
                    end
                end
                StLuStall: begin
                    // E holds the bubble, so lu is not re-evaluated here.
                    if (branch_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                        state_d = StBrFlush;
                    end else begin
                        state_d = StRun;
                    end
                end
                StBrFlush: begin
                    // Whatever sits in E now came from a flushed slot.
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Decode-side forwarding compares for the instruction about to enter E.
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!(flush_E || stall_D)) begin
            fwd_a_d = fwd_sel(regAD, regScr_E, regw_E, regScr_M, regw_M);
            fwd_b_d = fwd_sel(regBD, regScr_E, regw_E, regScr_M, regw_M);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Forward selects, valid while the matching instruction sits in E.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwdA_E = fwd_a_q;
    assign fwdB_E = fwd_b_q;

`ifdef STALL_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters; flush_D is only ever raised by a branch redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_D && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (flush_D && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases with literal expectations,
// then random traffic checked every cycle against an event-level model.
module tb_hazard_ctrl;
    localparam int unsigned M      = 4;
    localparam int unsigned CW     = 4;
    localparam int          CntSat = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [M-1:0]  regAD, regBD, regScr_E, regScr_M;
    logic          regw_E, regmem_E, regw_M, branch_E;
    logic          stall_F, stall_D, flush_D, flush_E;
    logic [1:0]    fwdA_E, fwdB_E;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errs   = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.M(M), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .regAD    (regAD),
        .regBD    (regBD),
        .regScr_E (regScr_E),
        .regw_E   (regw_E),
        .regmem_E (regmem_E),
        .regScr_M (regScr_M),
        .regw_M   (regw_M),
        .branch_E (branch_E),
        .stall_F  (stall_F),
        .stall_D  (stall_D),
        .flush_D  (flush_D),
        .flush_E  (flush_E),
        .fwdA_E   (fwdA_E),
        .fwdB_E   (fwdB_E),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    // ---------------- reference model ----------------
    // Pipeline memory: did the previous cycle redirect, or stall on a load-use?
    bit         m_prev_br = 1'b0;
    bit         m_prev_lu = 1'b0;
    logic [1:0] m_fa = 2'b00;
    logic [1:0] m_fb = 2'b00;
    int         m_sc = 0;
    int         m_fc = 0;

    function automatic logic [1:0] ref_fwd(input logic [M-1:0] src, input logic [M-1:0] de,
                                           input logic we, input logic [M-1:0] dm,
                                           input logic wm);
        if (src == 0) return 2'b00;
        if (we && src == de) return 2'b10;
        if (wm && src == dm) return 2'b01;
        return 2'b00;
    endfunction

    // Returns {stall_F, stall_D, flush_D, flush_E}.
    function automatic logic [3:0] ref_ctl(input bit r, input bit prev_br, input bit prev_lu,
                                           input bit br, input bit lu_hit);
        if (!r) return 4'b0001;
        if (prev_br) return 4'b0000;
        if (br) return 4'b0011;
        if (prev_lu) return 4'b0000;
        if (lu_hit) return 4'b1101;
        return 4'b0000;
    endfunction

    logic       exp_lu;
    logic [3:0] exp_ctl;
    assign exp_lu  = regmem_E && regw_E && (regScr_E != 0) &&
                     ((regScr_E == regAD) || (regScr_E == regBD));
    assign exp_ctl = ref_ctl(rst, m_prev_br, m_prev_lu, branch_E, exp_lu);

    always @(posedge clk) begin
        if (!rst) begin
            m_prev_br <= 1'b0;
            m_prev_lu <= 1'b0;
            m_fa      <= 2'b00;
            m_fb      <= 2'b00;
            m_sc      <= 0;
            m_fc      <= 0;
        end else begin
            m_prev_br <= exp_ctl[1];
            m_prev_lu <= exp_ctl[2];
            m_fa <= (exp_ctl[0] || exp_ctl[2]) ? 2'b00 :
                    ref_fwd(regAD, regScr_E, regw_E, regScr_M, regw_M);
            m_fb <= (exp_ctl[0] || exp_ctl[2]) ? 2'b00 :
                    ref_fwd(regBD, regScr_E, regw_E, regScr_M, regw_M);
            if (exp_ctl[2] && m_sc < CntSat) m_sc <= m_sc + 1;
            if (exp_ctl[1] && m_fc < CntSat) m_fc <= m_fc + 1;
        end
    end

    logic [CW-1:0] exp_sc, exp_fc;
`ifdef STALL_CNT_EN
    assign exp_sc = CW'(m_sc);
    assign exp_fc = CW'(m_fc);
`else
    assign exp_sc = '0;
    assign exp_fc = '0;
`endif

    // Per-cycle comparison against the model, 2 time units after inputs change.
    always begin
        @(negedge clk);
        #2;
        if (cmp_en) begin
            checks++;
            if ({stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, stall_cnt, flush_cnt} !==
                {exp_ctl, m_fa, m_fb, exp_sc, exp_fc}) begin
                errs++;
                $display("FAIL model_cycle t=%0t got ctl=%b fa=%b fb=%b sc=%0d fc=%0d exp ctl=%b fa=%b fb=%b sc=%0d fc=%0d",
                         $time, {stall_F, stall_D, flush_D, flush_E}, fwdA_E, fwdB_E,
                         stall_cnt, flush_cnt, exp_ctl, m_fa, m_fb, exp_sc, exp_fc);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [M-1:0] ad, input logic [M-1:0] bd,
                          input logic [M-1:0] se, input logic we, input logic me,
                          input logic [M-1:0] sm, input logic wm, input logic br);
        regAD    = ad;
        regBD    = bd;
        regScr_E = se;
        regw_E   = we;
        regmem_E = me;
        regScr_M = sm;
        regw_M   = wm;
        branch_E = br;
    endtask

    task automatic idle();
        set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        set_in(4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [3:0] ctl();
        return {stall_F, stall_D, flush_D, flush_E};
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        #3;
        chk("reset_ctl", 32'(ctl()), 32'h1);
        chk("reset_fwd", 32'({fwdA_E, fwdB_E}), 32'h0);
        chk("reset_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);

        @(negedge clk); rst = 1'b1; idle(); #3;
        chk("run_idle_ctl", 32'(ctl()), 32'h0);

        // Load-use: one stall cycle, then RUN with a bubble in E.
        @(negedge clk); load_use(); #3;
        chk("lu_stall", 32'(ctl()), 32'hD);
        @(negedge clk); #3;
        chk("lu_single_cycle", 32'(ctl()), 32'h0);
        chk("lu_fwdA_bubble", 32'(fwdA_E), 32'h0);
        @(negedge clk); idle();

        // Double forward: E producer wins, then M producer alone.
        @(negedge clk); set_in(4'd0, 4'd5, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0); #3;
        chk("dfwd_no_stall", 32'(ctl()), 32'h0);
        @(negedge clk); set_in(4'd0, 4'd5, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0); #3;
        chk("dfwd_B_10", 32'(fwdB_E), 32'h2);
        @(negedge clk); idle(); #3;
        chk("dfwd_B_01", 32'(fwdB_E), 32'h1);
        chk("dfwd_A_00", 32'(fwdA_E), 32'h0);

        // Register 0 is never a hazard or forwarding source.
        @(negedge clk); set_in(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); #3;
        chk("reg0_no_stall", 32'(ctl()), 32'h0);
        @(negedge clk); idle(); #3;
        chk("reg0_fwd", 32'({fwdA_E, fwdB_E}), 32'h0);

        // Branch and load-use together: branch wins; next branch is ignored.
        @(negedge clk); set_in(4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1); #3;
        chk("br_vs_lu", 32'(ctl()), 32'h3);
        @(negedge clk); #3;
        chk("br_flush_ignore", 32'(ctl()), 32'h0);
        chk("br_flush_fwd", 32'(fwdA_E), 32'h0);
        @(negedge clk); idle();

        // Reset during the stall drops it.
        @(negedge clk); load_use(); #3;
        chk("rst_mid_stall_pre", 32'(ctl()), 32'hD);
        @(negedge clk); rst = 1'b0; #3;
        chk("rst_mid_stall_hold", 32'(ctl()), 32'h1);
        @(negedge clk); rst = 1'b1; idle(); #3;
        chk("rst_mid_stall_ctl", 32'(ctl()), 32'h0);
        chk("rst_mid_stall_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);

        // 20 back-to-back load-use stalls saturate a 4-bit counter.
        @(negedge clk); load_use();
        repeat (39) @(negedge clk);
        idle(); #3;
`ifdef STALL_CNT_EN
        chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
`else
        chk("stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif

        // Three branch redirects while branch_E is held high.
        @(negedge clk); set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        idle(); #3;
`ifdef STALL_CNT_EN
        chk("flush_cnt_3", 32'(flush_cnt), 32'd3);
`else
        chk("flush_cnt_off", 32'(flush_cnt), 32'd0);
`endif

        // Random traffic on a narrow address range to provoke hits.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(99) < 3) ? 1'b0 : 1'b1;
            regAD    = M'($urandom_range(3));
            regBD    = M'($urandom_range(3));
            regScr_E = M'($urandom_range(3));
            regScr_M = M'($urandom_range(3));
            regw_E   = 1'($urandom_range(1));
            regmem_E = 1'($urandom_range(1));
            regw_M   = 1'($urandom_range(1));
            branch_E = ($urandom_range(99) < 20) ? 1'b1 : 1'b0;
        end

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
